// File: rtl/dlo_dual_rail_rx.sv
// Receiver for the DLO dual-rail precharge/evaluate link: detects spacer/codeword phases,
// decodes completed words into a small FIFO, flags protocol faults. Optional: DLO_RX_PARITY_EN.
module dlo_dual_rail_rx #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             CP,
  input  logic             RN,
  input  logic [WIDTH-1:0] DR_T,
  input  logic [WIDTH-1:0] DR_F,
`ifdef DLO_RX_PARITY_EN
  input  logic             DP_T,
  input  logic             DP_F,
  output logic             ERR_PAR,
`endif
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             ERR_RAIL,
  output logic             ERR_TMO,
  output logic [7:0]       DROP_CNT,
  input  logic             ERR_CLR,
  output logic             BUSY
);

  localparam int AW = $clog2(DEPTH);
`ifdef DLO_RX_PARITY_EN
  localparam int EW = WIDTH + 1;
  logic [EW-1:0] in_t, in_f;
  assign in_t = {DP_T, DR_T};
  assign in_f = {DP_F, DR_F};
`else
  localparam int EW = WIDTH;
  logic [EW-1:0] in_t, in_f;
  assign in_t = DR_T;
  assign in_f = DR_F;
`endif

  typedef enum logic {W_SPACER, W_DATA} state_t;

  logic [EW-1:0] rt_reg, rf_reg;
  logic [EW-1:0] bit_spacer, bit_valid, bit_illegal;
  logic          all_spacer, all_valid, any_illegal, parity_ok;
  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          push, set_rail, set_tmo, set_par;

  always_ff @(posedge CP) begin
    if (!RN) begin
      rt_reg <= '0;
      rf_reg <= '0;
    end else begin
      rt_reg <= in_t;
      rf_reg <= in_f;
    end
  end

  generate
    for (genvar gi = 0; gi < EW; gi++) begin : g_bit
      assign bit_spacer[gi]  = ~rt_reg[gi] & ~rf_reg[gi];
      assign bit_valid[gi]   = rt_reg[gi] ^ rf_reg[gi];
      assign bit_illegal[gi] = rt_reg[gi] & rf_reg[gi];
    end
  endgenerate

  assign all_spacer  = &bit_spacer;
  assign all_valid   = &bit_valid;
  assign any_illegal = |bit_illegal;
`ifdef DLO_RX_PARITY_EN
  assign parity_ok = ~^rt_reg;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge CP) begin
    if (!RN) begin
      state_reg <= W_SPACER;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    push       = 1'b0;
    set_rail   = 1'b0;
    set_tmo    = 1'b0;
    set_par    = 1'b0;
    if (any_illegal) begin
      set_rail   = 1'b1;
      state_next = W_SPACER;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        W_SPACER: begin
          cnt_next = '0;
          if (all_spacer) state_next = W_DATA;
        end
        default: begin
          if (all_valid) begin
            state_next = W_SPACER;
            cnt_next   = '0;
            if (parity_ok) push = 1'b1;
            else           set_par = 1'b1;
          end else if (all_spacer) begin
            cnt_next = '0;
          end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
            // This partial cycle is the TIMEOUT-th one: abandon the word.
            set_tmo    = 1'b1;
            state_next = W_SPACER;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      endcase
    end
  end

  assign BUSY = (state_reg == W_DATA) && !all_spacer;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic             empty, full, pop, push_ok, drop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop     = !empty && O_READY;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge CP) begin
    if (RN && push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= rt_reg[WIDTH-1:0];
  end

  always_ff @(posedge CP) begin
    if (!RN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Stale RAM contents are masked so an empty FIFO always presents zero.
  assign O_VALID = !empty;
  assign O_DATA  = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

  logic       err_rail_reg, err_tmo_reg;
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge CP) begin
    if (!RN) begin
      err_rail_reg <= 1'b0;
      err_tmo_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      err_rail_reg <= set_rail | (err_rail_reg & ~ERR_CLR);
      err_tmo_reg  <= set_tmo  | (err_tmo_reg  & ~ERR_CLR);
      if (drop)
        drop_cnt_reg <= ERR_CLR ? 8'd1 : ((drop_cnt_reg == 8'hFF) ? 8'hFF : drop_cnt_reg + 8'd1);
      else if (ERR_CLR)
        drop_cnt_reg <= '0;
    end
  end

  assign ERR_RAIL = err_rail_reg;
  assign ERR_TMO  = err_tmo_reg;
  assign DROP_CNT = drop_cnt_reg;

`ifdef DLO_RX_PARITY_EN
  logic err_par_reg;
  always_ff @(posedge CP) begin
    if (!RN) err_par_reg <= 1'b0;
    else     err_par_reg <= set_par | (err_par_reg & ~ERR_CLR);
  end
  assign ERR_PAR = err_par_reg;
`else
  logic unused_par;
  assign unused_par = set_par;
`endif

endmodule

// File: tb/tb_dlo_dual_rail_rx.sv
// Bench for dlo_dual_rail_rx: vector table, directed corner sequences and random traffic
// compared against a queue-based behavioural model of the link receiver.
module tb_dlo_dual_rail_rx;
`ifdef DLO_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int TMO = 15;

  logic       CP = 1'b0;
  logic       RN = 1'b0;
  logic [7:0] DR_T = '0, DR_F = '0;
  logic       dp_t = 1'b0, dp_f = 1'b0;
  logic [7:0] O_DATA;
  logic       O_VALID, O_READY = 1'b0, ERR_RAIL, ERR_TMO, ERR_CLR = 1'b0, BUSY;
  logic [7:0] DROP_CNT;
  logic       err_par;

  dlo_dual_rail_rx #(.WIDTH(8), .DEPTH(4), .TIMEOUT(TMO)) dut (
    .CP(CP), .RN(RN), .DR_T(DR_T), .DR_F(DR_F),
`ifdef DLO_RX_PARITY_EN
    .DP_T(dp_t), .DP_F(dp_f), .ERR_PAR(err_par),
`endif
    .O_DATA(O_DATA), .O_VALID(O_VALID), .O_READY(O_READY),
    .ERR_RAIL(ERR_RAIL), .ERR_TMO(ERR_TMO), .DROP_CNT(DROP_CNT),
    .ERR_CLR(ERR_CLR), .BUSY(BUSY)
  );
`ifndef DLO_RX_PARITY_EN
  assign err_par = 1'b0;
`endif

  always #5 CP = ~CP;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [8:0] m_pt, m_pf;
  bit         m_armed;
  int         m_partial;
  logic [7:0] q[$];
  bit         m_rail, m_tmo, m_par;
  int         m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_out();
    return {12'd0, O_VALID, O_DATA, ERR_RAIL, ERR_TMO, err_par, DROP_CNT, BUSY};
  endfunction

  function automatic logic [31:0] model_out();
    logic [7:0] head;
    bit busy;
    head = (q.size() > 0) ? q[0] : 8'h00;
    busy = m_armed && ((m_pt | m_pf) != 9'd0);
    return {12'd0, q.size() > 0, head, m_rail, m_tmo, m_par, 8'(m_drop), busy};
  endfunction

  task automatic model_reset();
    m_pt = '0; m_pf = '0; m_armed = 0; m_partial = 0;
    q.delete(); m_rail = 0; m_tmo = 0; m_par = 0; m_drop = 0;
  endtask

  // One clock edge of the receiver as seen from its rules, using last edge's sampled rails.
  task automatic model_step(input bit rdy, input bit clr);
    bit ill, spc, comp, push, er, et, ep, pop, full, drop;
    ill  = |(m_pt & m_pf);
    spc  = (m_pt | m_pf) == 9'd0;
    comp = PAR ? &(m_pt ^ m_pf) : &(m_pt[7:0] ^ m_pf[7:0]);
    push = 0; er = 0; et = 0; ep = 0; drop = 0;
    if (ill) begin
      er = 1; m_armed = 0; m_partial = 0;
    end else if (!m_armed) begin
      if (spc) m_armed = 1;
    end else if (comp) begin
      m_armed = 0; m_partial = 0;
      if (PAR && (^m_pt)) ep = 1; else push = 1;
    end else if (spc) begin
      m_partial = 0;
    end else begin
      m_partial++;
      if (m_partial == TMO) begin et = 1; m_armed = 0; m_partial = 0; end
    end
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == 4);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (full && !pop) drop = 1;
      else q.push_back(m_pt[7:0]);
    end
    m_rail = er | (m_rail & !clr);
    m_tmo  = et | (m_tmo & !clr);
    m_par  = ep | (m_par & !clr);
    if (drop) m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    else if (clr) m_drop = 0;
  endtask

  task automatic cycle(input logic [7:0] t, input logic [7:0] f, input logic dpt, input logic dpf,
                       input logic rdy, input logic clr);
    @(negedge CP);
    RN = 1'b1; DR_T = t; DR_F = f; dp_t = dpt; dp_f = dpf; O_READY = rdy; ERR_CLR = clr;
    @(posedge CP);
    model_step(rdy, clr);
    m_pt = {PAR ? dpt : 1'b0, t};
    m_pf = {PAR ? dpf : 1'b0, f};
    #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic spacer(input logic rdy);
    cycle(8'h00, 8'h00, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic word(input logic [7:0] w, input logic rdy);
    cycle(w, ~w, ^w, ~(^w), rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CP);
    RN = 1'b0;
    @(posedge CP);
    model_reset();
    #1;
    chk("reset", dut_out(), 32'd0);
  endtask

  typedef struct {
    logic [7:0] t, f;
    logic       rdy, clr;
    logic       v;
    logic [7:0] d;
    logic       rail, busy;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{8'hA5, 8'h5A, 1, 0, 0, 8'h00, 0, 1};
    vecs[3]  = '{8'hA5, 8'h5A, 1, 0, 1, 8'hA5, 0, 0};
    vecs[4]  = '{8'hA5, 8'h5A, 1, 0, 0, 8'h00, 0, 0};
    vecs[5]  = '{8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0};
    vecs[6]  = '{8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0};
    vecs[7]  = '{8'h80, 8'h80, 1, 0, 0, 8'h00, 0, 1};
    vecs[8]  = '{8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    vecs[9]  = '{8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    vecs[10] = '{8'h3C, 8'hC3, 1, 0, 0, 8'h00, 1, 1};
    vecs[11] = '{8'h00, 8'h00, 1, 0, 1, 8'h3C, 1, 0};
    vecs[12] = '{8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    vecs[13] = '{8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0};

    model_reset();
    do_reset();
    do_reset();

    // Table: single codeword held 3 cycles, then illegal rail, recovery, clear
    for (int i = 0; i < 14; i++) begin
      logic cw;
      cw = ((vecs[i].t ^ vecs[i].f) == 8'hFF);
      cycle(vecs[i].t, vecs[i].f, cw ? ^vecs[i].t : 1'b0, cw ? ~(^vecs[i].t) : 1'b0,
            vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d", i), {O_VALID, O_DATA, ERR_RAIL, BUSY},
          {vecs[i].v, vecs[i].d, vecs[i].rail, vecs[i].busy});
    end

    // Overflow: five words with no reader, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      spacer(1'b0);
      word(8'(i), 1'b0);
    end
    spacer(1'b0);
    chk("ovf_state", {O_VALID, O_DATA, DROP_CNT}, {1'b1, 8'h01, 8'd1});
    for (int k = 2; k <= 4; k++) begin
      spacer(1'b1);
      chk($sformatf("drain%0d", k), {O_VALID, O_DATA}, {1'b1, 8'(k)});
    end
    spacer(1'b1);
    chk("drain_empty", {O_VALID, O_DATA}, {1'b0, 8'h00});

    // Timeout on a stalled partial word
    do_reset();
    spacer(1'b1);
    for (int j = 1; j <= 20; j++) begin
      cycle(8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      if (j == 15) chk("tmo_before", {ERR_TMO, BUSY}, 2'b01);
      if (j == 16) chk("tmo_set", {ERR_TMO, BUSY}, 2'b10);
    end
    chk("tmo_end", {ERR_TMO, BUSY, O_VALID}, 3'b100);

    // Full FIFO with a push coinciding with a pop
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      spacer(1'b0);
      word(8'h10 + 8'(i), 1'b0);
    end
    spacer(1'b1);
    chk("full_pushpop", {O_VALID, O_DATA, DROP_CNT}, {1'b1, 8'h12, 8'd0});
    for (int k = 0; k < 4; k++) spacer(1'b1);
    chk("full_drained", {O_VALID, DROP_CNT}, {1'b0, 8'd0});

    // Reset in the middle of a codeword
    spacer(1'b0);
    cycle(8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_busy", {12'd0, BUSY}, 13'd1);
    do_reset();
    spacer(1'b1);
    word(8'h5C, 1'b0);
    spacer(1'b0);
    chk("post_reset_word", {O_VALID, O_DATA, ERR_RAIL, ERR_TMO}, {1'b1, 8'h5C, 2'b00});

`ifdef DLO_RX_PARITY_EN
    do_reset();
    spacer(1'b1);
    cycle(8'h03, 8'hFC, 1'b1, 1'b0, 1'b1, 1'b0);
    spacer(1'b0);
    chk("par_bad", {O_VALID, err_par}, 2'b01);
    cycle(8'h03, 8'hFC, 1'b0, 1'b1, 1'b0, 1'b0);
    spacer(1'b0);
    chk("par_good", {O_VALID, O_DATA}, {1'b1, 8'h03});
`endif

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] t, f, w;
      logic dpt, dpf, rdy, clr;
      r   = $urandom_range(0, 9);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      t = 8'h00; f = 8'h00; dpt = 1'b0; dpf = 1'b0;
      if (r >= 4 && r <= 6) begin
        w = 8'($urandom);
        t = w; f = ~w;
        dpt = (^w) ^ ($urandom_range(0, 7) == 0);
        dpf = ~dpt;
      end else if (r == 7 || r == 8) begin
        t = 8'($urandom) & 8'($urandom);
      end else if (r == 9 && $urandom_range(0, 3) == 0) begin
        t = 8'h01 << $urandom_range(0, 7);
        f = t;
      end
      cycle(t, f, dpt, dpf, rdy, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
